// File: rtl/pcm_frame_packer.sv
// Packs a backpressure-free PCM sample stream into FRAME_LEN-sample frames
// through a two-bank RAM and streams each frame out as AXI4-Stream with tlast.
module pcm_frame_packer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pcm_data,
  input  logic              pcm_data_valid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  input  logic              clear_overflow
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_e;

  logic [DATA_W-1:0] mem [2*FRAME_LEN];
  logic [DATA_W-1:0] mem_q;

  logic [1:0]        bank_full;
  logic              wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_bank;
  logic [IDX_W-1:0]  fetch_idx;
  rd_state_e         state;

  logic              pend_v;
  logic              pend_last;
  logic              skid_v;
  logic              skid_last;
  logic [DATA_W-1:0] skid_data;

  logic              wr_ok;
  logic              wr_done;
  logic              drop;
  logic              pop;
  logic              out_free;
  logic [1:0]        occ;
  logic              issue;
  logic              rd_done;
  logic              tvalid_n;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;

  // Free status is the registered bank_full, so a release and a write to the
  // same bank on one edge still drops the sample.
  assign wr_ok   = pcm_data_valid && !bank_full[wr_bank];
  assign drop    = pcm_data_valid &&  bank_full[wr_bank];
  assign wr_done = wr_ok && (wr_idx == LAST_IDX);

  // Output holding stage: out register + skid register + one RAM read in
  // flight. A read is issued only if its data is sure to find a slot.
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign out_free = !m_axis_tvalid || pop;
  assign occ      = {1'b0, m_axis_tvalid} + {1'b0, skid_v} + {1'b0, pend_v};
  assign issue    = bank_full[rd_bank] && (pop || (occ < 2'd2));
  assign rd_done  = issue && (fetch_idx == LAST_IDX);
  assign tvalid_n = !out_free || skid_v || pend_v;

  // A bank is released once its last word has been read out of the RAM; the
  // tail of the frame already lives in the holding stage, which is what lets
  // a sample every cycle stream with no drops.
  assign set_mask = wr_done ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = rd_done ? (2'b01 << rd_bank) : 2'b00;

  // NOTE: sample storage has no reset; stale words are never exposed because
  // only banks marked full are read, and reset clears every full flag.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_bank, wr_idx}] <= pcm_data;
    if (issue) mem_q <= mem[{rd_bank, fetch_idx}];
  end

  // NOTE: all state below uses non-blocking assignments so every decision in
  // this cycle sees the values registered before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full     <= '0;
      wr_bank       <= 1'b0;
      wr_idx        <= '0;
      rd_bank       <= 1'b0;
      fetch_idx     <= '0;
      state         <= IDLE;
      pend_v        <= 1'b0;
      pend_last     <= 1'b0;
      skid_v        <= 1'b0;
      skid_last     <= 1'b0;
      skid_data     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      overflow      <= 1'b0;
      drop_count    <= '0;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;

      if (wr_ok) begin
        wr_idx <= wr_done ? '0 : wr_idx + IDX_W'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end

      if (issue) begin
        fetch_idx <= rd_done ? '0 : fetch_idx + IDX_W'(1);
        if (rd_done) rd_bank <= ~rd_bank;
      end
      pend_v    <= issue;
      pend_last <= rd_done;

      if (out_free) begin
        if (skid_v) begin
          m_axis_tdata  <= skid_data;
          m_axis_tlast  <= skid_last;
          m_axis_tvalid <= 1'b1;
        end else if (pend_v) begin
          m_axis_tdata  <= mem_q;
          m_axis_tlast  <= pend_last;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
      end

      if ((out_free && skid_v) || (!out_free && pend_v)) begin
        skid_v    <= pend_v;
        skid_data <= mem_q;
        skid_last <= pend_last;
      end

      case (state)
        IDLE:    if (issue) state <= FETCH;
        FETCH:   state <= STREAM;
        STREAM:  if (!tvalid_n) state <= issue ? FETCH : IDLE;
        default: state <= IDLE;
      endcase

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (clear_overflow)  drop_count <= CNT_W'(1);
        else if (!(&drop_count)) drop_count <= drop_count + CNT_W'(1);
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Self-checking bench for pcm_frame_packer with FRAME_LEN=8 and a 4-bit
// drop counter so saturation is reachable.
module tb_pcm_frame_packer;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] pcm_data = '0;
  logic              pcm_data_valid = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clear_overflow = 1'b0;

  pcm_frame_packer #(
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcm_data      (pcm_data),
    .pcm_data_valid(pcm_data_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic             valid;
    logic             clear;
    logic             exp_ovf;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    model_idx = 0;
  logic  rand_ready = 1'b0;
  logic  ready_fixed = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: accepted samples leave in arrival order, cut into
  // frames of FRAME_LEN with tlast on the final one.
  task automatic model_push(input logic [DATA_W-1:0] d);
    beat_t b;
    b.data = d;
    b.last = (model_idx == FRAME_LEN - 1);
    exp_q.push_back(b);
    model_idx = (model_idx + 1) % FRAME_LEN;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: collects handshaken beats and checks stability under stall.
  initial begin
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", 32'(m_axis_tvalid), 32'(1));
          check("stall_tdata", 32'(m_axis_tdata), 32'(prev_data));
          check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
        end
        if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tdata, m_axis_tlast});
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int gap);
    pcm_data       = d;
    pcm_data_valid = 1'b1;
    tick(1);
    pcm_data_valid = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst            = 1'b0;
    pcm_data_valid = 1'b0;
    clear_overflow = 1'b0;
    rand_ready     = 1'b0;
    ready_fixed    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    tick(1);
    got_q.delete();
    exp_q.delete();
    model_idx = 0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check({name, "_beats"}, 32'(got_q.size()), 32'(n));
  endtask

  task automatic compare(input string name);
    int i = 0;
    while (exp_q.size() > 0) begin
      beat_t e;
      beat_t g;
      if (got_q.size() == 0) begin
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check($sformatf("%s_data[%0d]", name, i), 32'(g.data), 32'(e.data));
      check($sformatf("%s_last[%0d]", name, i), 32'(g.last), 32'(e.last));
      i++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lat;
    logic seen;
    int   c;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 4'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'd2};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4'd3};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 4'd4};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 4'd5};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 4'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 4'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 4'd0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 4'd1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 4'd0};

    // Reset values
    #12;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("rst_tlast", 32'(m_axis_tlast), 32'(0));
    check("rst_tdata", 32'(m_axis_tdata), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_drop_count", 32'(drop_count), 32'(0));

    // 1: single frame, sparse input, latency bound
    do_reset();
    ready_fixed = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      send(DATA_W'(i), 4);
      model_push(DATA_W'(i));
    end
    send(DATA_W'(8), 1);
    model_push(DATA_W'(8));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      if (m_axis_tvalid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check("t1_first_valid_within_3", 32'(seen && lat <= 3), 32'(1));
    wait_beats(8, 60, "t1");
    compare("t1");
    check("t1_overflow", 32'(overflow), 32'(0));

    // 2: both banks fill under stall, third frame dropped
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      send(DATA_W'(i), 2);
      if (i <= 16) model_push(DATA_W'(i));
    end
    check("t2_overflow", 32'(overflow), 32'(1));
    check("t2_drop_count", 32'(drop_count), 32'(8));
    check("t2_held_tvalid", 32'(m_axis_tvalid), 32'(1));
    check("t2_held_tdata", 32'(m_axis_tdata), 32'(1));
    check("t2_no_early_beats", 32'(got_q.size()), 32'(0));
    ready_fixed = 1'b1;
    wait_beats(16, 100, "t2a");
    compare("t2a");
    for (int i = 25; i <= 32; i++) begin
      send(DATA_W'(i), 2);
      model_push(DATA_W'(i));
    end
    wait_beats(8, 100, "t2b");
    compare("t2b");

    // 3: random data, random 50% tready
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      send(d, 4);
      model_push(d);
    end
    wait_beats(64, 2000, "t3");
    compare("t3");
    check("t3_overflow", 32'(overflow), 32'(0));
    rand_ready = 1'b0;

    // 4: a sample every cycle with tready held high
    do_reset();
    ready_fixed = 1'b1;
    tick(2);
    for (int i = 0; i < 32; i++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      pcm_data       = d;
      pcm_data_valid = 1'b1;
      model_push(d);
      tick(1);
    end
    pcm_data_valid = 1'b0;
    wait_beats(32, 200, "t4");
    compare("t4");
    check("t4_drop_count", 32'(drop_count), 32'(0));
    check("t4_overflow", 32'(overflow), 32'(0));

    // 5: overflow / clear interaction and saturation with both banks full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(DATA_W'(16'h0100 + i), 1);
      model_push(DATA_W'(16'h0100 + i));
    end
    check("t5_pre_overflow", 32'(overflow), 32'(0));
    for (int i = 0; i < 10; i++) begin
      pcm_data       = 16'hdead;
      pcm_data_valid = vecs[i].valid;
      clear_overflow = vecs[i].clear;
      tick(1);
      pcm_data_valid = 1'b0;
      clear_overflow = 1'b0;
      check($sformatf("t5_vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("t5_vec%0d_drop_count", i), 32'(drop_count), 32'(vecs[i].exp_cnt));
    end
    for (int i = 0; i < 20; i++) send(16'hbeef, 1);
    check("t5_saturated", 32'(drop_count), 32'(15));
    send(16'hbeef, 1);
    check("t5_saturated_hold", 32'(drop_count), 32'(15));
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("t5_cleared_overflow", 32'(overflow), 32'(0));
    check("t5_cleared_count", 32'(drop_count), 32'(0));
    ready_fixed = 1'b1;
    wait_beats(16, 100, "t5");
    compare("t5");
    tick(20);
    check("t5_no_extra_beats", 32'(got_q.size()), 32'(0));

    // 6: reset in the middle of a streaming frame
    do_reset();
    for (int i = 1; i <= 24; i++) send(DATA_W'(16'h0010 + i), 1);
    check("t6_pre_overflow", 32'(overflow), 32'(1));
    ready_fixed = 1'b1;
    c = 0;
    while (got_q.size() < 3 && c < 100) begin
      tick(1);
      c++;
    end
    check("t6_beat3_valid", 32'(m_axis_tvalid), 32'(1));
    check("t6_beat3_data", 32'(m_axis_tdata), 32'(16'h0014));
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("t6_rst_tlast", 32'(m_axis_tlast), 32'(0));
    check("t6_rst_overflow", 32'(overflow), 32'(0));
    check("t6_rst_drop_count", 32'(drop_count), 32'(0));
    for (int i = 0; i < 3; i++) model_push(DATA_W'(16'h0011 + i));
    compare("t6_pre");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    tick(1);
    got_q.delete();
    exp_q.delete();
    model_idx = 0;
    for (int i = 0; i < 8; i++) begin
      send(DATA_W'(16'h00a0 + i), 1);
      model_push(DATA_W'(16'h00a0 + i));
    end
    wait_beats(8, 100, "t6");
    compare("t6");
    tick(30);
    check("t6_no_stale_beats", 32'(got_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
